// File: rtl/cluster_mem_pkg.sv
// Shared types and constants for the cluster memory responder.
package cluster_mem_pkg;

  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned OFF_W      = 4;
  localparam int unsigned WORD_W     = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [2:0] {
    FETCH,
    LOAD,
    STORE,
    PTE_RD,
    PTE_WR
  } kind_e;

  function automatic logic kind_is_write(input kind_e k);
    return (k == STORE) || (k == PTE_WR);
  endfunction

endpackage

// File: rtl/cluster_wmask_gen.sv
// Store byte-enable and replicated write-line generation from size, offset and data.
module cluster_wmask_gen
  import cluster_mem_pkg::*;
(
  input  logic [1:0]   size_i,
  input  logic [3:0]   off_i,
  input  logic [31:0]  wdata_i,
  output logic [15:0]  wmask_c_o,
  output logic [127:0] wline_c_o
);

  logic [31:0] word_c;

  // Sub-word stores replicate their pattern across the word; size 3 behaves as word.
  always_comb begin
    wmask_c_o = 16'h000F << {off_i[3:2], 2'b00};
    word_c    = wdata_i;
    case (size_i)
      SZ_B: begin
        wmask_c_o = 16'h0001 << off_i;
        word_c    = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        wmask_c_o = 16'h0003 << {off_i[3:1], 1'b0};
        word_c    = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
    wline_c_o = {4{word_c}};
  end

endmodule

// File: rtl/cluster_mem_responder.sv
// Sequences cluster fetch/load/store/PTE requests onto a single 128-bit line memory port.
// Optional response timeout is enabled with `define CLUSTER_RSP_TIMEOUT_EN.
module cluster_mem_responder
  import cluster_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                w_cluster_req,
  input  logic [ADDR_W-1:0]   w_cluster_iaddr,
  input  logic [ADDR_W-1:0]   w_cluster_daddr,
  input  logic [31:0]         w_cluster_data_wdata,
  input  logic [2:0]          w_cluster_data_ctrl,
  input  logic                w_cluster_data_we,
  input  logic                w_cluster_iscode,
  input  logic                w_cluster_isread,
  input  logic                w_cluster_tlb_acs,
  input  logic [ADDR_W-1:0]   w_cluster_tlb_pte_addr,
  input  logic                w_cluster_pte_we,
  input  logic [31:0]         w_cluster_pte_wdata,
  output logic                w_busy,
  output logic                w_dram_busy,
  output logic [LINE_W-1:0]   w_insn_data,
  output logic [LINE_W-1:0]   w_data_data,
  output logic                w_is_dram_data,
  output logic [31:0]         w_dram_odata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [LINE_W-1:0]   mem_wdata,
  output logic [LINE_W/8-1:0] mem_wmask,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [LINE_W-1:0]   mem_rdata,
  output logic                rsp_err
);

  localparam int unsigned MASK_W = LINE_W / 8;

  state_e state_q, state_d;
  kind_e  kind_q, kind_c;
  logic [1:0] wsel_q;

  logic              any_c, accept_c, tmo_c, err_set_c, rd_fire_c, unused_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [1:0]        gen_size_c;
  logic [31:0]       gen_wdata_c;
  logic [MASK_W-1:0] gen_mask_c;
  logic [LINE_W-1:0] gen_line_c, rd_line_c;

  logic              busy_d, mem_req_d, mem_we_d, is_dram_d, err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_d, insn_d, data_d;
  logic [MASK_W-1:0] mem_wmask_d;
  logic [31:0]       odata_d;

  // Request decode: PTE access beats store beats load beats fetch.
  always_comb begin
    kind_c = FETCH;
    any_c  = 1'b1;
    if (w_cluster_tlb_acs)      kind_c = w_cluster_pte_we ? PTE_WR : PTE_RD;
    else if (w_cluster_data_we) kind_c = STORE;
    else if (w_cluster_isread)  kind_c = LOAD;
    else if (w_cluster_iscode)  kind_c = FETCH;
    else                        any_c  = 1'b0;
    acc_addr_c = w_cluster_daddr;
    if (kind_c == PTE_RD || kind_c == PTE_WR) acc_addr_c = w_cluster_tlb_pte_addr;
    else if (kind_c == FETCH)                 acc_addr_c = w_cluster_iaddr;
    gen_size_c  = (kind_c == PTE_WR) ? SZ_W : w_cluster_data_ctrl[1:0];
    gen_wdata_c = (kind_c == PTE_WR) ? w_cluster_pte_wdata : w_cluster_data_wdata;
  end

  assign accept_c = (state_q == IDLE) && w_cluster_req && any_c;

  cluster_wmask_gen u_wmask_gen (
    .size_i    (gen_size_c),
    .off_i     (acc_addr_c[OFF_W-1:0]),
    .wdata_i   (gen_wdata_c),
    .wmask_c_o (gen_mask_c),
    .wline_c_o (gen_line_c)
  );

`ifdef CLUSTER_RSP_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST)                                          tmo_cnt_q <= '0;
    else if (state_d != state_q)                      tmo_cnt_q <= '0;
    else if (state_q == ISSUE || state_q == WAIT)     tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign tmo_c     = (state_q == ISSUE || state_q == WAIT) && (tmo_cnt_q == 16'(TIMEOUT - 1));
  assign err_set_c = tmo_c && !((state_q == WAIT && mem_rvalid) || (state_q == ISSUE && mem_ready));
  assign unused_c  = w_cluster_data_ctrl[2];
`else
  assign tmo_c     = 1'b0;
  assign err_set_c = 1'b0;
  assign unused_c  = ^{w_cluster_data_ctrl[2], 32'(TIMEOUT)};
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept_c) state_d = ISSUE;
      ISSUE: begin
        if (mem_ready)  state_d = kind_is_write(kind_q) ? RESP : WAIT;
        else if (tmo_c) state_d = RESP;
      end
      WAIT:  if (mem_rvalid || tmo_c) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read responses (real or timed-out) update the matching data register on RESP entry.
  assign rd_fire_c = (state_d == RESP) && (state_q != RESP) && !kind_is_write(kind_q);
  assign rd_line_c = (state_q == WAIT && mem_rvalid) ? mem_rdata : '0;

  always_comb begin
    busy_d      = (state_d == ISSUE) || (state_d == WAIT);
    mem_req_d   = (state_d == ISSUE);
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wmask_d = mem_wmask;
    insn_d      = w_insn_data;
    data_d      = w_data_data;
    odata_d     = w_dram_odata;
    is_dram_d   = 1'b0;
    err_d       = rsp_err | err_set_c;
    if (accept_c) begin
      mem_we_d    = kind_is_write(kind_c);
      mem_addr_d  = {acc_addr_c[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      mem_wdata_d = kind_is_write(kind_c) ? gen_line_c : '0;
      mem_wmask_d = kind_is_write(kind_c) ? gen_mask_c : '0;
    end
    if (rd_fire_c) begin
      case (kind_q)
        FETCH:   insn_d  = rd_line_c;
        LOAD:    begin data_d = rd_line_c; is_dram_d = 1'b1; end
        PTE_RD:  odata_d = rd_line_c[{wsel_q, 5'b00000} +: WORD_W];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      kind_q         <= FETCH;
      wsel_q         <= '0;
      w_busy         <= 1'b0;
      w_dram_busy    <= 1'b0;
      w_insn_data    <= '0;
      w_data_data    <= '0;
      w_is_dram_data <= 1'b0;
      w_dram_odata   <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      rsp_err        <= 1'b0;
    end else begin
      if (accept_c) begin
        kind_q <= kind_c;
        wsel_q <= acc_addr_c[3:2];
      end
      w_busy         <= busy_d;
      w_dram_busy    <= busy_d;
      w_insn_data    <= insn_d;
      w_data_data    <= data_d;
      w_is_dram_data <= is_dram_d;
      w_dram_odata   <= odata_d;
      mem_req        <= mem_req_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_wdata      <= mem_wdata_d;
      mem_wmask      <= mem_wmask_d;
      rsp_err        <= err_d;
    end
  end

endmodule
